set_associative_cache: RTL and testbench

SET_ASSOCIATIVE_CACHE -- requirements
Module: set_associative_cache

---
 rtl/set_associative_cache_pkg.sv | 40 ++++
 rtl/cache_way_array.sv | 69 ++++++
 rtl/set_associative_cache.sv | 244 ++++++++++++++++++++++++
 tb/tb_set_associative_cache.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/set_associative_cache_pkg.sv
// -----------------------------------------------------------------------------
// set_associative_cache_pkg
// Shared types and helpers for the 2-way set-associative, write-through cache.
//   state_e      : controller states (IDLE, MEM_REQ, MEM_WAIT)
//   NUM_WAYS     : associativity
//   line_t       : one cache line as seen by the lookup logic (valid, tag, data)
//   index_width  : set-index width for a given number of sets
//   tag_width    : tag width for a given address width and number of sets
// -----------------------------------------------------------------------------
package set_associative_cache_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

    localparam int NUM_WAYS = 2;

    // Tags are zero-extended into this field so line_t does not depend on
    // the address-width parameter of a particular instance.
    localparam int TAG_MAX_W = 64;

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [31:0]          data;
    } line_t;

    // Lines are one 32-bit word, so the two lowest address bits are the
    // byte offset and never take part in index or tag.
    function automatic int index_width(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_width(input int addr_w, input int sets);
        return addr_w - $clog2(sets) - 2;
    endfunction

endpackage

// File: rtl/cache_way_array.sv
// -----------------------------------------------------------------------------
// cache_way_array
// Storage for one way: a valid bit, a tag and a 32-bit data word per set.
//   clk, reset          : clock, asynchronous active-high reset (clears valid)
//   rd_idx_i            : set index for the combinational read port
//   rd_valid_o/tag/data : contents of the addressed set
//   wr_en_i             : write strobe; writes tag, sets valid
//   wr_idx_i, wr_tag_i  : set index and tag to write
//   wr_data_i, wr_be_i  : data word and byte mask (only enabled bytes change)
// -----------------------------------------------------------------------------
module cache_way_array
    import set_associative_cache_pkg::*;
#(
    parameter int SETS  = 8,
    parameter int TAG_W = 27,
    localparam int IDX_W = index_width(SETS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_valid_o,
    output logic [TAG_W-1:0] rd_tag_o,
    output logic [31:0]      rd_data_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  logic [31:0]      wr_data_i,
    input  logic [3:0]       wr_be_i
);

    logic [SETS-1:0] valid_q;
    logic [SETS-1:0] valid_d;
    logic [TAG_W-1:0] tag_mem  [SETS];
    logic [31:0]      data_mem [SETS];

    // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it holding its old value (which would infer a latch).
    always_comb begin
        valid_d = valid_q;
        if (wr_en_i) begin
            valid_d[wr_idx_i] = 1'b1;
        end
    end

    // NOTE: clocked blocks use non-blocking assignments so every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // NOTE: tag/data storage is deliberately not reset; the valid bits alone decide whether an entry means anything, and the arrays can then map to plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_mem[wr_idx_i] <= wr_tag_i;
            for (int b = 0; b < 4; b++) begin
                if (wr_be_i[b]) begin
                    data_mem[wr_idx_i][8*b +: 8] <= wr_data_i[8*b +: 8];
                end
            end
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_mem[rd_idx_i];
    assign rd_data_o  = data_mem[rd_idx_i];

endmodule

// File: rtl/set_associative_cache.sv
// -----------------------------------------------------------------------------
// set_associative_cache
// 2-way set-associative, write-through cache, one 32-bit word per line,
// one LRU bit per set. Read hits answer one cycle after the grant; misses
// and all writes go to memory through MEM_REQ / MEM_WAIT.
//
// Configuration macro: CACHE_WRITE_ALLOCATE_EN
//   defined   : a write miss with all four byte enables installs the line
//   undefined : write misses never allocate
//
// Ports
//   clk, reset                  : clock, asynchronous active-high reset
//   core_req_i / core_gnt_o     : core request, accepted when granted (IDLE only)
//   core_addr_i, core_we_i      : word-aligned byte address, 1 = write
//   core_wdata_i, core_be_i     : write data and byte enables
//   core_rvalid_o               : one-cycle response pulse
//   core_rdata_o, core_error_o  : response data and error, with core_rvalid_o
//   mem_req_o / mem_gnt_i       : memory request, held until granted
//   mem_addr_o, mem_we_o        : memory address and write enable
//   mem_wdata_o, mem_be_o       : memory write data and byte enables
//   mem_rvalid_i                : memory response valid
//   mem_rdata_i, mem_error_i    : memory response data and error
// -----------------------------------------------------------------------------
module set_associative_cache
    import set_associative_cache_pkg::*;
#(
    parameter int SETS       = 8,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] core_addr_i,
    input  logic [31:0]           core_wdata_i,
    input  logic                  core_we_i,
    input  logic                  core_req_i,
    input  logic [3:0]            core_be_i,
    output logic [31:0]           core_rdata_o,
    output logic                  core_gnt_o,
    output logic                  core_rvalid_o,
    output logic                  core_error_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    output logic                  mem_we_o,
    output logic                  mem_req_o,
    output logic [3:0]            mem_be_o,
    input  logic [31:0]           mem_rdata_i,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic                  mem_error_i
);

    localparam int IDX_W = index_width(SETS);
    localparam int TAG_W = tag_width(ADDR_WIDTH, SETS);

`ifdef CACHE_WRITE_ALLOCATE_EN
    localparam bit WRITE_ALLOCATE = 1'b1;
`else
    localparam bit WRITE_ALLOCATE = 1'b0;
`endif

    state_e                state_q, state_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [3:0]            mem_be_q, mem_be_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic                  core_rvalid_q, core_rvalid_d;
    logic                  core_error_q, core_error_d;
    logic [31:0]           core_rdata_q, core_rdata_d;
    // lru_q[set] names the least recently used way of that set.
    logic [SETS-1:0]       lru_q, lru_d;

    // Lookup port: the live core address while idle, the latched request
    // address while a memory transaction is in flight.
    logic [ADDR_WIDTH-1:0] lk_addr;
    logic [IDX_W-1:0]      lk_idx;
    logic [TAG_W-1:0]      lk_tag;
    logic [1:0]            unused_lk_offset;

    logic                  way_valid [NUM_WAYS];
    logic [TAG_W-1:0]      way_tag   [NUM_WAYS];
    logic [31:0]           way_data  [NUM_WAYS];
    line_t                 way_line  [NUM_WAYS];
    logic [NUM_WAYS-1:0]   hit;
    logic                  hit_any;
    logic                  hit_way;
    logic                  victim_way;
    logic                  done;

    logic [NUM_WAYS-1:0]   wr_en;
    logic [31:0]           wr_data;
    logic [3:0]            wr_be;

    assign lk_addr          = (state_q == IDLE) ? core_addr_i : mem_addr_q;
    assign lk_idx           = lk_addr[IDX_W+1:2];
    assign lk_tag           = lk_addr[ADDR_WIDTH-1:IDX_W+2];
    assign unused_lk_offset = lk_addr[1:0];

    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
        cache_way_array #(
            .SETS  (SETS),
            .TAG_W (TAG_W)
        ) u_way (
            .clk        (clk),
            .reset      (reset),
            .rd_idx_i   (lk_idx),
            .rd_valid_o (way_valid[w]),
            .rd_tag_o   (way_tag[w]),
            .rd_data_o  (way_data[w]),
            .wr_en_i    (wr_en[w]),
            .wr_idx_i   (lk_idx),
            .wr_tag_i   (lk_tag),
            .wr_data_i  (wr_data),
            .wr_be_i    (wr_be)
        );
    end

    always_comb begin
        for (int w = 0; w < NUM_WAYS; w++) begin
            way_line[w] = '{valid: way_valid[w],
                            tag:   TAG_MAX_W'(way_tag[w]),
                            data:  way_data[w]};
            hit[w] = way_line[w].valid && (way_line[w].tag == TAG_MAX_W'(lk_tag));
        end
        hit_any = |hit;
        hit_way = hit[1];
        // Fill an empty way before evicting; way 0 when both are empty.
        if (!way_line[0].valid) begin
            victim_way = 1'b0;
        end else if (!way_line[1].valid) begin
            victim_way = 1'b1;
        end else begin
            victim_way = lru_q[lk_idx];
        end
    end

    // A transaction completes on the memory response; a grant and response in
    // the same cycle complete straight out of MEM_REQ.
    assign done = mem_rvalid_i &&
                  ((state_q == MEM_WAIT) || ((state_q == MEM_REQ) && mem_gnt_i));

    always_comb begin
        state_d       = state_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_be_d      = mem_be_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        core_rvalid_d = 1'b0;
        core_error_d  = 1'b0;
        core_rdata_d  = core_rdata_q;
        lru_d         = lru_q;
        wr_en         = '0;
        wr_data       = mem_wdata_q;
        wr_be         = mem_be_q;

        case (state_q)
            IDLE: begin
                if (core_req_i) begin
                    if (!core_we_i && hit_any) begin
                        core_rvalid_d  = 1'b1;
                        core_rdata_d   = way_line[hit_way].data;
                        lru_d[lk_idx]  = ~hit_way;
                    end else begin
                        state_d     = MEM_REQ;
                        mem_req_d   = 1'b1;
                        mem_addr_d  = core_addr_i;
                        mem_we_d    = core_we_i;
                        mem_be_d    = core_we_i ? core_be_i : 4'b1111;
                        mem_wdata_d = core_wdata_i;
                    end
                end
            end
            MEM_REQ: begin
                if (mem_gnt_i) begin
                    mem_req_d = 1'b0;
                    state_d   = MEM_WAIT;
                end
            end
            MEM_WAIT: ;
            default: state_d = IDLE;
        endcase

        if (done) begin
            state_d       = IDLE;
            mem_req_d     = 1'b0;
            core_rvalid_d = 1'b1;
            core_error_d  = mem_error_i;
            core_rdata_d  = mem_rdata_i;
            if (mem_we_q) begin
                // Write-through: the hit way merges even when memory flagged an error.
                if (hit_any) begin
                    wr_en[hit_way] = 1'b1;
                    lru_d[lk_idx]  = ~hit_way;
                end else if (WRITE_ALLOCATE && (mem_be_q == 4'b1111) && !mem_error_i) begin
                    wr_en[victim_way] = 1'b1;
                    lru_d[lk_idx]     = ~victim_way;
                end
            end else if (!mem_error_i) begin
                wr_en[victim_way] = 1'b1;
                wr_data           = mem_rdata_i;
                wr_be             = 4'b1111;
                lru_d[lk_idx]     = ~victim_way;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_be_q      <= '0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            core_rvalid_q <= 1'b0;
            core_error_q  <= 1'b0;
            core_rdata_q  <= '0;
            lru_q         <= '0;
        end else begin
            state_q       <= state_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_be_q      <= mem_be_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            core_rvalid_q <= core_rvalid_d;
            core_error_q  <= core_error_d;
            core_rdata_q  <= core_rdata_d;
            lru_q         <= lru_d;
        end
    end

    assign core_gnt_o    = core_req_i && (state_q == IDLE) && !reset;
    assign core_rvalid_o = core_rvalid_q;
    assign core_error_o  = core_error_q;
    assign core_rdata_o  = core_rdata_q;
    assign mem_req_o     = mem_req_q;
    assign mem_we_o      = mem_we_q;
    assign mem_be_o      = mem_be_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_wdata_o   = mem_wdata_q;

endmodule

// File: tb/tb_set_associative_cache.sv
// -----------------------------------------------------------------------------
// tb_set_associative_cache
// Directed test of set_associative_cache (SETS=8, 32-bit addresses) against a
// small behavioural memory. Unwritten memory words read as addr ^ 0x5A5A5A5A.
// Expectations adapt to CACHE_WRITE_ALLOCATE_EN when the bench is built with it.
// -----------------------------------------------------------------------------
module tb_set_associative_cache;

    localparam int SETS = 8;
    localparam int AW   = 32;
`ifdef CACHE_WRITE_ALLOCATE_EN
    localparam int ALLOC = 1;
`else
    localparam int ALLOC = 0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] core_addr_i;
    logic [31:0]   core_wdata_i;
    logic          core_we_i;
    logic          core_req_i;
    logic [3:0]    core_be_i;
    logic [31:0]   core_rdata_o;
    logic          core_gnt_o;
    logic          core_rvalid_o;
    logic          core_error_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_wdata_o;
    logic          mem_we_o;
    logic          mem_req_o;
    logic [3:0]    mem_be_o;
    logic [31:0]   mem_rdata_i;
    logic          mem_gnt_i;
    logic          mem_rvalid_i;
    logic          mem_error_i;

    always #5 clk = ~clk;

    set_associative_cache #(.SETS(SETS), .ADDR_WIDTH(AW)) dut (
        .clk           (clk),
        .reset         (reset),
        .core_addr_i   (core_addr_i),
        .core_wdata_i  (core_wdata_i),
        .core_we_i     (core_we_i),
        .core_req_i    (core_req_i),
        .core_be_i     (core_be_i),
        .core_rdata_o  (core_rdata_o),
        .core_gnt_o    (core_gnt_o),
        .core_rvalid_o (core_rvalid_o),
        .core_error_o  (core_error_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_we_o      (mem_we_o),
        .mem_req_o     (mem_req_o),
        .mem_be_o      (mem_be_o),
        .mem_rdata_i   (mem_rdata_i),
        .mem_gnt_i     (mem_gnt_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_error_i   (mem_error_i)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pat(input logic [31:0] a);
        return a ^ 32'h5A5A_5A5A;
    endfunction

    // ---------------- memory model / responder ----------------
    int          mem_lat      = 1;   // cycles from grant to response, 0 = same cycle
    bit          mem_err_next = 1'b0;
    bit          no_resp      = 1'b0;
    int          grants       = 0;
    logic [31:0] last_addr    = '0;
    logic        last_we      = 1'b0;
    logic [3:0]  last_be      = '0;
    logic [31:0] mem_model [logic [31:0]];

    initial begin
        bit          pending;
        int          cnt;
        logic [31:0] word;
        logic        resp_err;
        pending     = 1'b0;
        cnt         = 0;
        resp_err    = 1'b0;
        mem_gnt_i   = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_error_i = 1'b0;
        mem_rdata_i = '0;
        forever begin
            @(negedge clk);
            mem_gnt_i    = 1'b0;
            mem_rvalid_i = 1'b0;
            mem_error_i  = 1'b0;
            if (pending) begin
                if (cnt == 0) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = word;
                    mem_error_i  = resp_err;
                    pending      = 1'b0;
                end else begin
                    cnt--;
                end
            end else if (mem_req_o) begin
                mem_gnt_i = 1'b1;
                grants++;
                last_addr = mem_addr_o;
                last_we   = mem_we_o;
                last_be   = mem_be_o;
                word = mem_model.exists(mem_addr_o) ? mem_model[mem_addr_o] : pat(mem_addr_o);
                if (mem_we_o) begin
                    for (int b = 0; b < 4; b++) begin
                        if (mem_be_o[b]) word[8*b +: 8] = mem_wdata_o[8*b +: 8];
                    end
                    mem_model[mem_addr_o] = word;
                end
                resp_err = mem_err_next;
                if (!no_resp) begin
                    if (mem_lat == 0) begin
                        mem_rvalid_i = 1'b1;
                        mem_rdata_i  = word;
                        mem_error_i  = resp_err;
                    end else begin
                        pending = 1'b1;
                        cnt     = mem_lat - 1;
                    end
                end
            end
        end
    end

    // ---------------- core-side transaction ----------------
    // lat = number of cycles from the grant cycle to the rvalid cycle.
    task automatic xact(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                        input logic [3:0] be, output logic [31:0] rdata,
                        output logic err, output int lat);
        bit got;
        rdata = '0;
        err   = 1'b0;
        lat   = -1;
        @(negedge clk);
        core_req_i   = 1'b1;
        core_addr_i  = addr;
        core_we_i    = we;
        core_wdata_i = wdata;
        core_be_i    = be;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            #1;
            if (core_gnt_o) got = 1'b1;
            else @(negedge clk);
        end
        if (!got) begin
            check("gnt_timeout", {31'b0, got}, 32'd1);
            core_req_i = 1'b0;
            return;
        end
        @(negedge clk);
        core_req_i = 1'b0;
        got = 1'b0;
        for (int i = 1; i <= 50 && !got; i++) begin
            if (core_rvalid_o) begin
                got   = 1'b1;
                lat   = i;
                rdata = core_rdata_o;
                err   = core_error_o;
            end else begin
                @(negedge clk);
            end
        end
        if (!got) check("rvalid_timeout", {31'b0, got}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, 32'({core_gnt_o, core_rvalid_o, core_error_o,
                                   mem_req_o, mem_we_o, mem_be_o}), 32'd0);
        check({tag, "_mem_addr"},  mem_addr_o,   32'd0);
        check({tag, "_mem_wdata"}, mem_wdata_o,  32'd0);
        check({tag, "_rdata"},     core_rdata_o, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          g0;
        int          early;
        int          rv;
        bit          got;

        reset        = 1'b1;
        core_req_i   = 1'b0;
        core_addr_i  = '0;
        core_wdata_i = '0;
        core_we_i    = 1'b0;
        core_be_i    = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;

        // Write-through then read of the same word.
        xact(32'h0010_0000, 1'b1, 32'h1234_ABCD, 4'hF, rd, er, lat);
        check("wr_lat", lat, 3);
        check("wr_mem_addr", last_addr, 32'h0010_0000);
        check("wr_mem_we", {31'b0, last_we}, 32'd1);
        check("wr_mem_data", mem_model[32'h0010_0000], 32'h1234_ABCD);
        g0 = grants;
        xact(32'h0010_0000, 1'b0, 32'h0, 4'hF, rd, er, lat);
        check("rd_after_wr_lat", lat, (ALLOC != 0) ? 1 : 3);
        check("rd_after_wr_memreq", grants - g0, (ALLOC != 0) ? 0 : 1);
        check("rd_after_wr_data", rd, 32'h1234_ABCD);
        @(negedge clk);
        check("rvalid_single_pulse", {31'b0, core_rvalid_o}, 32'd0);

        // Cold read miss, then hit.
        g0 = grants;
        xact(32'h0010_0200, 1'b0, 32'hDEAD_BEEF, 4'h0, rd, er, lat);
        check("cold_lat", lat, 3);
        check("cold_memreq", grants - g0, 1);
        check("cold_mem_addr", last_addr, 32'h0010_0200);
        check("cold_mem_we_be", {27'b0, last_we, last_be}, 32'h0000_000F);
        check("cold_data", rd, pat(32'h0010_0200));
        g0 = grants;
        xact(32'h0010_0200, 1'b0, 32'h0, 4'hF, rd, er, lat);
        check("rehit_lat", lat, 1);
        check("rehit_memreq", grants - g0, 0);
        check("rehit_data", rd, pat(32'h0010_0200));

        // LRU: make 0x00100000 MRU, 0x00100300 then evicts 0x00100200.
        xact(32'h0010_0000, 1'b0, 32'h0, 4'hF, rd, er, lat);
        check("mru_touch_lat", lat, 1);
        xact(32'h0010_0300, 1'b0, 32'h0, 4'hF, rd, er, lat);
        check("evict_lat", lat, 3);
        check("evict_data", rd, pat(32'h0010_0300));
        g0 = grants;
        xact(32'h0010_0000, 1'b0, 32'h0, 4'hF, rd, er, lat);
        check("kept_lat", lat, 1);
        check("kept_memreq", grants - g0, 0);
        g0 = grants;
        xact(32'h0010_0200, 1'b0, 32'h0, 4'hF, rd, er, lat);
        check("evicted_memreq", grants - g0, 1);

        // Partial write hit merges bytes into the line.
        xact(32'h0010_0000, 1'b1, 32'hFFFF_5678, 4'b0011, rd, er, lat);
        check("merge_mem_data", mem_model[32'h0010_0000], 32'h1234_5678);
        g0 = grants;
        xact(32'h0010_0000, 1'b0, 32'h0, 4'hF, rd, er, lat);
        check("merge_hit_memreq", grants - g0, 0);
        check("merge_hit_data", rd, 32'h1234_5678);

        // Write hit with memory error still merges.
        mem_err_next = 1'b1;
        xact(32'h0010_0000, 1'b1, 32'hAAAA_0000, 4'b1100, rd, er, lat);
        mem_err_next = 1'b0;
        check("wr_err_flag", {31'b0, er}, 32'd1);
        xact(32'h0010_0000, 1'b0, 32'h0, 4'hF, rd, er, lat);
        check("wr_err_merge_data", rd, 32'hAAAA_5678);
        check("wr_err_merge_lat", lat, 1);

        // Read miss with error fills nothing.
        mem_err_next = 1'b1;
        xact(32'h0010_0404, 1'b0, 32'h0, 4'hF, rd, er, lat);
        mem_err_next = 1'b0;
        check("rd_err_flag", {31'b0, er}, 32'd1);
        g0 = grants;
        xact(32'h0010_0404, 1'b0, 32'h0, 4'hF, rd, er, lat);
        check("rd_err_remiss", grants - g0, 1);
        check("rd_err_clear", {31'b0, er}, 32'd0);
        check("rd_err_data", rd, pat(32'h0010_0404));

        // Grant and response in the same cycle.
        mem_lat = 0;
        xact(32'h0010_0008, 1'b0, 32'h0, 4'hF, rd, er, lat);
        mem_lat = 1;
        check("fast_lat", lat, 2);
        check("fast_data", rd, pat(32'h0010_0008));

        // Request held through a miss: no grant until the response returns.
        g0 = grants;
        @(negedge clk);
        core_req_i  = 1'b1;
        core_addr_i = 32'h0010_000C;
        core_we_i   = 1'b0;
        core_be_i   = 4'hF;
        #1;
        check("held_first_gnt", {31'b0, core_gnt_o}, 32'd1);
        early = 0;
        got   = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            #1;
            if (core_rvalid_o) got = 1'b1;
            else if (core_gnt_o) early++;
        end
        check("held_resp_seen", {31'b0, got}, 32'd1);
        check("held_no_early_gnt", early, 0);
        check("held_gnt_in_idle", {31'b0, core_gnt_o}, 32'd1);
        check("held_miss_data", core_rdata_o, pat(32'h0010_000C));
        @(negedge clk);
        core_req_i = 1'b0;
        check("held_second_rvalid", {31'b0, core_rvalid_o}, 32'd1);
        check("held_second_data", core_rdata_o, pat(32'h0010_000C));
        check("held_memreq", grants - g0, 1);

        // Reset while waiting for memory abandons the transaction.
        no_resp = 1'b1;
        @(negedge clk);
        core_req_i   = 1'b1;
        core_addr_i  = 32'h0010_0010;
        core_we_i    = 1'b0;
        core_wdata_i = 32'hDEAD_BEEF;
        #1;
        check("midrst_gnt", {31'b0, core_gnt_o}, 32'd1);
        @(negedge clk);
        core_req_i = 1'b0;
        @(negedge clk);
        #1;
        check("midrst_wait_addr", mem_addr_o, 32'h0010_0010);
        reset = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        reset   = 1'b0;
        no_resp = 1'b0;
        rv = 0;
        repeat (5) begin
            @(negedge clk);
            if (core_rvalid_o) rv++;
        end
        check("midrst_no_response", rv, 0);
        g0 = grants;
        xact(32'h0010_0000, 1'b0, 32'h0, 4'hF, rd, er, lat);
        check("postrst_miss", grants - g0, 1);
        check("postrst_lat", lat, 3);
        check("postrst_data", rd, 32'hAAAA_5678);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
